// File: rtl/game_pkg.sv
// Shared types, result encodings and widths for the number-guessing game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        ROUND_END,
        DONE
    } state_t;

    localparam int ROUND_W = 2;
    localparam int TIMER_W = 7;
    localparam int GUESS_W = 3;

    localparam logic [1:0] RESULT_NONE = 2'd0;
    localparam logic [1:0] RESULT_WIN  = 2'd1;
    localparam logic [1:0] RESULT_LOSE = 2'd2;

    function automatic logic [GUESS_W-1:0] satInc(input logic [GUESS_W-1:0] value,
                                                  input logic [GUESS_W-1:0] limit);
        return (value >= limit) ? limit : value + GUESS_W'(1);
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk_i,
    input  logic restart_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The count holds while disabled so a round can only restart it through clear.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (restart_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Game sequencer: round/timer/guess bookkeeping, confirm edge detection and result reporting.
module round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned ROUND_SECONDS = 30,
    parameter int unsigned NUM_ROUNDS    = 3,
    parameter int unsigned MAX_GUESSES   = 5
) (
    input  logic               clk_i,
    input  logic               restart_i,
    input  logic               start_i,
    input  logic               confirmButton_i,
    input  logic               guess_correct_i,
    output logic [ROUND_W-1:0] round_o,
    output logic [TIMER_W-1:0] timer_o,
    output logic [GUESS_W-1:0] incorrect_guesses_o,
    output logic [GUESS_W-1:0] guesses_left_o,
    output logic               load_secret_o,
    output logic               round_active_o,
    output logic               round_done_o,
    output logic [1:0]         WINorLOSE_o
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(ROUND_SECONDS);
    localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS);
    localparam logic [GUESS_W-1:0] GUESS_LIMIT = GUESS_W'(MAX_GUESSES);

    state_t             state_q;
    logic [ROUND_W-1:0] round_q;
    logic [TIMER_W-1:0] timer_q;
    logic [GUESS_W-1:0] incorrect_q;
    logic               loadSecret_q;
    logic               roundActive_q;
    logic               roundDone_q;
    logic [1:0]         result_q;
    logic               roundWon_q;
    logic               confirm_q;

    logic               tick;
    logic               prescClear;
    logic               prescEnable;
    logic               confirmEdge;
    logic               rightGuess;
    logic               wrongGuess;
    logic               timeout;
    logic [TIMER_W-1:0] timer_d;
    logic [GUESS_W-1:0] incorrect_d;

    assign prescClear  = (state_q == LOAD);
    assign prescEnable = (state_q == PLAY);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk_i    (clk_i),
        .restart_i(restart_i),
        .clear_i  (prescClear),
        .enable_i (prescEnable),
        .tick_o   (tick)
    );

    always_comb begin
        confirmEdge = confirmButton_i & ~confirm_q;
        rightGuess  = confirmEdge & guess_correct_i;
        wrongGuess  = confirmEdge & ~guess_correct_i;
        timeout     = tick && (timer_q == TIMER_W'(1));
        timer_d     = timer_q;
        if (tick) begin
            timer_d = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);
        end
        incorrect_d = wrongGuess ? satInc(incorrect_q, GUESS_LIMIT) : incorrect_q;
    end

    // Outputs are set on the edge entering the state they belong to, so they stay registered.
    always_ff @(posedge clk_i) begin
        if (restart_i) begin
            state_q       <= IDLE;
            round_q       <= '0;
            timer_q       <= '0;
            incorrect_q   <= '0;
            loadSecret_q  <= 1'b0;
            roundActive_q <= 1'b0;
            roundDone_q   <= 1'b0;
            result_q      <= RESULT_NONE;
            roundWon_q    <= 1'b0;
            confirm_q     <= 1'b0;
        end else begin
            confirm_q    <= confirmButton_i;
            loadSecret_q <= 1'b0;
            roundDone_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q      <= LOAD;
                        round_q      <= ROUND_W'(1);
                        result_q     <= RESULT_NONE;
                        loadSecret_q <= 1'b1;
                    end
                end
                LOAD: begin
                    timer_q       <= TIMER_LOAD;
                    incorrect_q   <= '0;
                    roundActive_q <= 1'b1;
                    state_q       <= PLAY;
                end
                PLAY: begin
                    timer_q     <= timer_d;
                    incorrect_q <= incorrect_d;
                    // A correct guess wins even when the timer expires on the same edge.
                    if (rightGuess) begin
                        roundWon_q    <= 1'b1;
                        roundActive_q <= 1'b0;
                        roundDone_q   <= 1'b1;
                        state_q       <= ROUND_END;
                    end else if ((incorrect_d == GUESS_LIMIT) || timeout) begin
                        roundWon_q    <= 1'b0;
                        roundActive_q <= 1'b0;
                        roundDone_q   <= 1'b1;
                        state_q       <= ROUND_END;
                    end
                end
                ROUND_END: begin
                    if (roundWon_q && (round_q < LAST_ROUND)) begin
                        round_q      <= round_q + ROUND_W'(1);
                        loadSecret_q <= 1'b1;
                        state_q      <= LOAD;
                    end else begin
                        result_q <= roundWon_q ? RESULT_WIN : RESULT_LOSE;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign round_o             = round_q;
    assign timer_o             = timer_q;
    assign incorrect_guesses_o = incorrect_q;
    assign guesses_left_o      = GUESS_LIMIT - incorrect_q;
    assign load_secret_o       = loadSecret_q;
    assign round_active_o      = roundActive_q;
    assign round_done_o        = roundDone_q;
    assign WINorLOSE_o         = result_q;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Controller that sequences the number-guessing game around `fsm`. It generates the per-round countdown `timer`, the `round` number and the `incorrect_guesses` count that `fsm` consumes. It edge-detects `confirmButton`, requests a new secret number per round and reports the final game result. It sits between the board I/O (button, start) and `fsm`, in the `clk` domain.

## Interface
- `TICKS_PER_SEC`, 50_000_000: `clk` cycles per timer second; must be ≥ 2.
- `ROUND_SECONDS`, 30: timer load value; range 1..127.
- `NUM_ROUNDS`, 3: rounds to win the game; range 1..3.
- `MAX_GUESSES`, 5: wrong guesses that lose a round; range 1..7.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `restart`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a game from IDLE or DONE.
- `confirmButton`  in  1  synchronized, debounced level; a guess is the 0→1 edge.
- `guess_correct`  in  1  comparator result; sampled on the confirm edge.
- `round`  out  2  current round, 1..NUM_ROUNDS; 0 when no game is running.
- `timer`  out  7  seconds left in the round.
- `incorrect_guesses`  out  3  wrong guesses this round.
- `guesses_left`  out  3  MAX_GUESSES − incorrect_guesses.
- `load_secret`  out  1  one-cycle pulse requesting a new secret number.
- `round_active`  out  1  high in PLAY only.
- `round_done`  out  1  one-cycle pulse in ROUND_END.
- `WINorLOSE`  out  2  0 = in progress, 1 = win, 2 = lose.

## Operation
- States: IDLE, LOAD, PLAY, ROUND_END, DONE.
- Reset (`restart`=1 at any edge, including mid-round): state = IDLE.
  - All outputs = 0, except `guesses_left` = MAX_GUESSES.
  - Prescaler = 0; confirm edge register = 0.
  - `restart` overrides `start` and all other inputs.
- IDLE, and DONE: `start` → LOAD with `round` ← 1 and `WINorLOSE` ← 0. Confirm edges are ignored.
- LOAD (1 cycle):
  - `load_secret` = 1.
  - `timer` ← ROUND_SECONDS, `incorrect_guesses` ← 0, prescaler ← 0.
  - Next state is PLAY.
- PLAY:
  - The prescaler counts 0..TICKS_PER_SEC−1 and wraps. A wrap is a tick, and a tick decrements `timer`.
  - Confirm edge = `confirmButton` & ~registered `confirmButton`. The edge register updates in every state.
  - Confirm edge with `guess_correct`=1 → ROUND_END, round won.
  - Confirm edge with `guess_correct`=0 → `incorrect_guesses`+1. If this reaches MAX_GUESSES → ROUND_END, round lost.
  - A tick with `timer`=1 → `timer` ← 0 and ROUND_END, round lost, on the same edge.
  - Simultaneous correct confirm and expiring tick: the win takes priority, and `timer` still updates to 0.
  - Simultaneous wrong confirm and non-expiring tick: both counters update.
- ROUND_END (1 cycle): `round_done` = 1; counters hold.
  - Won and `round` < NUM_ROUNDS → LOAD, `round`+1.
  - Won and `round` = NUM_ROUNDS → DONE, `WINorLOSE` ← 1.
  - Lost → DONE, `WINorLOSE` ← 2.
- DONE: all outputs hold until `start` or `restart`.
- Arithmetic:
  - `timer` saturates at 0.
  - `incorrect_guesses` never exceeds MAX_GUESSES.
  - `guesses_left` is combinational from `incorrect_guesses`.
  - The prescaler width is $clog2(TICKS_PER_SEC).

## Timing
- All outputs are registered except `guesses_left`, which is combinational.
- `start` at edge N:
  - LOAD in cycle N+1, with `load_secret` high.
  - PLAY from edge N+2, with `timer` = ROUND_SECONDS.
- First timer decrement: TICKS_PER_SEC cycles after PLAY entry.
- Confirm edge sampled at edge N: the counter or state updates at edge N. A held level produces no further events.
- Round loss by timeout: `timer` reads 0 in the ROUND_END cycle; DONE follows one cycle later.
- Between rounds: PLAY → ROUND_END → LOAD → PLAY, i.e. 2 cycles with `round_active` = 0.

## Structure
- Package `game_pkg`:
  - `state_t` enum.
  - `WINorLOSE` encodings: `RESULT_NONE`=0, `RESULT_WIN`=1, `RESULT_LOSE`=2.
  - Widths: `ROUND_W`=2, `TIMER_W`=7, `GUESS_W`=3.
- Sub-module `sec_prescaler`:
  - Inputs: `clk`, `restart`, `clear`, `enable`.
  - Output: one-cycle `tick`.
  - `clear` is driven high in LOAD; `enable` is driven high in PLAY.
- The FSM and counters live in `round_sequencer`.

## Test plan
Test parameters throughout: TICKS_PER_SEC=4, ROUND_SECONDS=3, NUM_ROUNDS=2, MAX_GUESSES=2.

1. `restart` then idle for 10 cycles: `round`=0, `timer`=0, `WINorLOSE`=0, `guesses_left`=2, no pulses.
2. `start`, no guesses: `load_secret` pulse, then `timer` 3→2→1→0 every 4 cycles. Then `round_done` pulse and `WINorLOSE`=2.
3. `start`, two rising edges with `guess_correct`=0: `incorrect_guesses` 1 then 2, `guesses_left` 0, `WINorLOSE`=2. Holding the button high for 5 cycles counts once.
4. `start`, correct guess in round 1, then correct guess in round 2: `round` 1→2, second `load_secret` pulse with `incorrect_guesses` reset to 0, final `WINorLOSE`=1.
5. Correct confirm edge on the same cycle as the tick taking `timer` 1→0: round is won and `round` advances to 2.
6. `restart` asserted mid-PLAY with `timer`=2, `incorrect_guesses`=1: next cycle all outputs are at reset values. A subsequent `start` begins at round 1.
